cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 170 +++++++++++++++++
 tb/tb_cache_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Purpose: arbitrates the instruction and data requesters onto one RAM port and checks every access against the ROM/RAM windows.
// Latency: a read acks in the 4th cycle after its request is sampled in IDLE; a write or an error acks in the 3rd.
// Backpressure: one access in flight; req is sampled only in IDLE and each requester holds req until its ack.
module cache_arbiter #(
    parameter logic [31:0] ROM_BASE = 32'h0000_0000,
    parameter logic [31:0] ROM_SIZE = 32'h0000_1000,
    parameter logic [31:0] RAM_BASE = 32'h0000_1000,
    parameter logic [31:0] RAM_SIZE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    // Latched copy of the winning request; everything after IDLE works from this.
    typedef struct packed {
        logic [63:0] addr;
        logic        we;
        logic [31:0] wdata;
    } acc_t;

    // Window bounds widened to 64 bits so base+size never wraps and the data
    // port's upper address bits take part in the comparison.
    localparam logic [63:0] ROM_LO = {32'd0, ROM_BASE};
    localparam logic [63:0] ROM_HI = ROM_LO + {32'd0, ROM_SIZE};
    localparam logic [63:0] RAM_LO = {32'd0, RAM_BASE};
    localparam logic [63:0] RAM_HI = RAM_LO + {32'd0, RAM_SIZE};
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    state_t state;
    state_t state_nxt;
    grant_t last_grant;
    grant_t grant_nxt;
    acc_t   acc_q;
    acc_t   acc_nxt;
    logic   any_req;
    logic   in_rom;
    logic   in_ram;
    logic   legal;

    assign any_req = i_req | d_req;

    // Round-robin winner selection and the request fields it would latch
    always_comb begin
        grant_nxt = last_grant;
        acc_nxt   = acc_q;
        if (i_req && d_req) begin
            grant_nxt = (last_grant == GNT_D) ? GNT_I : GNT_D;
        end else if (i_req) begin
            grant_nxt = GNT_I;
        end else if (d_req) begin
            grant_nxt = GNT_D;
        end
        if (grant_nxt == GNT_I) begin
            acc_nxt = '{addr: {32'd0, i_addr}, we: 1'b0, wdata: 32'd0};
        end else begin
            acc_nxt = '{addr: d_addr, we: d_we, wdata: d_wdata};
        end
    end

    // Address legality of the latched access: aligned, inside a window, and no ROM writes
    always_comb begin
        in_rom = (acc_q.addr >= ROM_LO) && (acc_q.addr < ROM_HI);
        in_ram = (acc_q.addr >= RAM_LO) && (acc_q.addr < RAM_HI);
        legal  = (acc_q.addr[1:0] == 2'b00) && (in_ram || (in_rom && !acc_q.we));
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: illegal accesses and writes skip the read-data wait
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_req) state_nxt = ADDR;
            ADDR: begin
                if (!legal || acc_q.we) state_nxt = RESP;
                else                    state_nxt = WAIT;
            end
            WAIT: state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the winner in IDLE; later input changes are ignored until the next IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= '0;
            last_grant <= GNT_D;
        end else if (state == IDLE && any_req) begin
            acc_q      <= acc_nxt;
            last_grant <= grant_nxt;
        end
    end

    assign mem_en    = (state == ADDR) && legal;
    assign mem_we    = mem_en && acc_q.we;
    assign mem_addr  = acc_q.addr[12:2];
    assign mem_wdata = acc_q.wdata;
    assign busy      = (state != IDLE);

    // Response path: read data captured in WAIT, ack/err pulsed from RESP, only for the owner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_err   <= 1'b0;
            d_err   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            i_err <= 1'b0;
            d_err <= 1'b0;
            if (state == WAIT) begin
                if (last_grant == GNT_I) i_rdata <= mem_rdata;
                else                     d_rdata <= mem_rdata;
            end
            if (state == RESP) begin
                if (last_grant == GNT_I) begin
                    i_ack <= 1'b1;
                    i_err <= !legal;
                    if (!legal) i_rdata <= ERR_DATA;
                end else begin
                    d_ack <= 1'b1;
                    d_err <= !legal;
                    if (!legal) d_rdata <= ERR_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Purpose: self-checking bench for cache_arbiter with a transaction-level timeline model and a RAM model.
// Latency: model expects read ack 4 cycles and write/error ack 3 cycles after the sampling cycle.
// Backpressure: requesters hold req until they see ack, then drop it (or occasionally keep it as a new request).
module tb_cache_arbiter;

    localparam logic [63:0] ROM_BASE = 64'h0000_0000;
    localparam logic [63:0] ROM_SIZE = 64'h0000_1000;
    localparam logic [63:0] RAM_BASE = 64'h0000_1000;
    localparam logic [63:0] RAM_SIZE = 64'h0000_1000;

    logic        clk;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    cache_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int k);
        if (k == 4) return 32'h1234_5678;
        return (32'(k) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic bit addr_ok(input logic [63:0] a, input bit we);
        bit rom, ram;
        rom = (a >= ROM_BASE) && (a < ROM_BASE + ROM_SIZE);
        ram = (a >= RAM_BASE) && (a < RAM_BASE + RAM_SIZE);
        return (a[1:0] == 2'b00) && (ram || (rom && !we));
    endfunction

    // ---------------- RAM model: responds one edge after mem_en ----------------
    logic [31:0] mem_arr [2048];
    initial begin
        logic        cap_en, cap_we;
        logic [10:0] cap_a;
        logic [31:0] cap_wd;
        for (int k = 0; k < 2048; k++) mem_arr[k] = init_word(k);
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            cap_en = mem_en; cap_we = mem_we; cap_a = mem_addr; cap_wd = mem_wdata;
            @(posedge clk);
            if (cap_en) begin
                mem_rdata = mem_arr[cap_a];
                if (cap_we) mem_arr[cap_a] = cap_wd;
            end
        end
    end

    // ---------------- Transaction timeline model ----------------
    // m_cnt counts cycles since the sampling cycle; the owner's ack lands at m_ack_at.
    bit          m_active, m_own, m_legal, m_we, last_g;
    int          m_cnt, m_ack_at;
    logic [10:0] m_word;
    logic [31:0] m_wd, m_pred;
    logic [31:0] exp_rd [2];
    logic [31:0] m_mem [2048];

    initial begin
        logic [63:0] a;
        bit idle_now;
        for (int k = 0; k < 2048; k++) m_mem[k] = init_word(k);
        m_active = 0; last_g = 1; m_cnt = 0; m_ack_at = 3;
        m_own = 0; m_legal = 0; m_we = 0; m_word = '0; m_wd = '0; m_pred = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_active = 0; last_g = 1; exp_rd[0] = '0; exp_rd[1] = '0;
            end else begin
                idle_now = !m_active || (m_cnt == m_ack_at);
                if (idle_now && (i_req || d_req)) begin
                    m_own   = (i_req && d_req) ? !last_g : d_req;
                    last_g  = m_own;
                    a       = m_own ? d_addr : {32'd0, i_addr};
                    m_we    = m_own ? d_we : 1'b0;
                    m_wd    = d_wdata;
                    m_legal = addr_ok(a, m_we);
                    m_word  = a[12:2];
                    m_ack_at = (m_legal && !m_we) ? 4 : 3;
                    if (m_legal && m_we)  m_mem[m_word] = m_wd;
                    if (m_legal && !m_we) m_pred = m_mem[m_word];
                    m_active = 1; m_cnt = 1;
                end else if (m_active) begin
                    m_cnt++;
                    if (m_cnt > m_ack_at) m_active = 0;
                    else if (m_cnt == m_ack_at) begin
                        if (!m_legal)   exp_rd[m_own] = 32'hDEAD_BEEF;
                        else if (!m_we) exp_rd[m_own] = m_pred;
                    end
                end
            end
        end
    end

    // ---------------- Per-cycle compare against the model ----------------
    initial begin
        bit act, e_busy, e_en, e_we, e_ai, e_ad, fl_i, fl_d;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                act    = m_active && (m_cnt <= m_ack_at);
                e_busy = act && (m_cnt < m_ack_at);
                e_en   = act && (m_cnt == 1) && m_legal;
                e_we   = e_en && m_we;
                e_ai   = act && (m_cnt == m_ack_at) && !m_own;
                e_ad   = act && (m_cnt == m_ack_at) && m_own;
                chk("busy", busy, e_busy);
                chk("mem_en", mem_en, e_en);
                chk("mem_we", mem_we, e_we);
                chk("i_ack", i_ack, e_ai);
                chk("d_ack", d_ack, e_ad);
                chk("i_err", i_err, e_ai && !m_legal);
                chk("d_err", d_err, e_ad && !m_legal);
                if (e_en) chk("mem_addr", mem_addr, m_word);
                if (e_we) chk("mem_wdata", mem_wdata, m_wd);
                fl_i = act && !m_own && (m_cnt < m_ack_at);
                fl_d = act && m_own && (m_cnt < m_ack_at);
                if (!fl_i) chk("i_rdata", i_rdata, exp_rd[0]);
                if (!fl_d) chk("d_rdata", d_rdata, exp_rd[1]);
            end
        end
    end

    // ---------------- Directed transaction helper ----------------
    int          r_ack_k, r_en, r_we, r_oth;
    logic [10:0] r_ma;
    logic [31:0] r_mwd, r_rd;
    logic        r_er;

    task automatic do_txn(input bit is_d, input bit we, input logic [63:0] addr, input logic [31:0] wd);
        r_ack_k = -1; r_en = 0; r_we = 0; r_oth = 0;
        r_ma = '0; r_mwd = '0; r_rd = '0; r_er = 1'bx;
        if (is_d) begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            i_req = 1; i_addr = addr[31:0];
        end
        for (int k = 1; k <= 12 && r_ack_k < 0; k++) begin
            @(posedge clk); #1;
            if (mem_en) begin r_en++; r_ma = mem_addr; end
            if (mem_we) begin r_we++; r_mwd = mem_wdata; end
            if (is_d ? d_ack : i_ack) begin
                r_ack_k = k;
                r_rd = is_d ? d_rdata : i_rdata;
                r_er = is_d ? d_err : i_err;
                i_req = 0; d_req = 0;
            end
            if (is_d ? i_ack : d_ack) r_oth++;
        end
        i_req = 0; d_req = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #3 reset_n = 0;
        @(posedge clk); @(posedge clk); #3 reset_n = 1;
    endtask

    function automatic logic [63:0] rand_d_addr();
        case ($urandom_range(0, 6))
            0, 1:    return 64'(4 * $urandom_range(0, 15));
            2, 3:    return 64'h1000 + 64'(4 * $urandom_range(0, 15));
            4:       return 64'h1000 + 64'($urandom_range(0, 63));
            5:       return 64'h2000 + 64'(4 * $urandom_range(0, 15));
            default: return {32'($urandom_range(1, 3)), 32'h0000_1000 + 32'(4 * $urandom_range(0, 15))};
        endcase
    endfunction

    function automatic logic [31:0] rand_i_addr();
        case ($urandom_range(0, 5))
            0, 1:    return 32'(4 * $urandom_range(0, 15));
            2, 3:    return 32'h1000 + 32'(4 * $urandom_range(0, 15));
            4:       return 32'($urandom_range(0, 63));
            default: return 32'h2000 + 32'(4 * $urandom_range(0, 15));
        endcase
    endfunction

    // ---------------- Main stimulus ----------------
    initial begin
        int seq [10];
        int n, both, no_ack;
        reset_n = 0; i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_i_ack", i_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        #11 reset_n = 1;
        @(posedge clk); #1;

        // Instruction read from ROM
        do_txn(0, 0, 64'h10, 32'h0);
        chk("t1_ack_cycle", r_ack_k, 4);
        chk("t1_mem_en_cnt", r_en, 1);
        chk("t1_mem_addr", r_ma, 11'h4);
        chk("t1_rdata", r_rd, 32'h1234_5678);
        chk("t1_err", r_er, 0);
        chk("t1_other_ack", r_oth, 0);

        // Data write into RAM, then read back
        do_txn(1, 1, 64'h1004, 32'hCAFE_F00D);
        chk("t2_ack_cycle", r_ack_k, 3);
        chk("t2_mem_en_cnt", r_en, 1);
        chk("t2_mem_we_cnt", r_we, 1);
        chk("t2_mem_addr", r_ma, 11'h401);
        chk("t2_mem_wdata", r_mwd, 32'hCAFE_F00D);
        chk("t2_err", r_er, 0);
        do_txn(1, 0, 64'h1004, 32'h0);
        chk("t2_rb_ack_cycle", r_ack_k, 4);
        chk("t2_rb_rdata", r_rd, 32'hCAFE_F00D);

        // Write to ROM is an error
        do_txn(1, 1, 64'h8, 32'h1111_2222);
        chk("t3_ack_cycle", r_ack_k, 3);
        chk("t3_mem_en_cnt", r_en, 0);
        chk("t3_mem_we_cnt", r_we, 0);
        chk("t3_err", r_er, 1);
        chk("t3_rdata", r_rd, 32'hDEAD_BEEF);

        // Upper-bit and misaligned data addresses, out-of-range fetch
        do_txn(1, 0, 64'h1_0000_1000, 32'h0);
        chk("t4a_err", r_er, 1);
        chk("t4a_mem_en_cnt", r_en, 0);
        chk("t4a_ack_cycle", r_ack_k, 3);
        do_txn(1, 0, 64'h1002, 32'h0);
        chk("t4b_err", r_er, 1);
        chk("t4b_mem_en_cnt", r_en, 0);
        do_txn(0, 0, 64'h2000, 32'h0);
        chk("t4c_err", r_er, 1);
        chk("t4c_rdata", r_rd, 32'hDEAD_BEEF);

        // Both held after reset: grants alternate starting with instruction
        do_reset();
        i_addr = 32'h20; d_addr = 64'h1008; d_we = 0; i_req = 1; d_req = 1;
        n = 0; both = 0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            @(posedge clk); #1;
            if (i_ack && d_ack) both++;
            if (i_ack && n < 10) begin seq[n] = 0; n++; end
            if (d_ack && n < 10) begin seq[n] = 1; n++; end
        end
        i_req = 0; d_req = 0;
        chk("t5_grant_count", n, 8);
        chk("t5_dual_ack", both, 0);
        for (int g = 0; g < 8 && g < n; g++) chk($sformatf("t5_order%0d", g), seq[g], g % 2);

        // Reset pulsed during WAIT
        repeat (3) @(posedge clk);
        #1;
        d_req = 1; d_we = 0; d_addr = 64'h1010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_busy_in_wait", busy, 1);
        #2 reset_n = 0;
        #1;
        chk("t6_busy_rst", busy, 0);
        chk("t6_d_ack_rst", d_ack, 0);
        chk("t6_i_ack_rst", i_ack, 0);
        chk("t6_mem_en_rst", mem_en, 0);
        chk("t6_d_rdata_rst", d_rdata, 0);
        chk("t6_i_rdata_rst", i_rdata, 0);
        d_req = 0;
        @(posedge clk); #3 reset_n = 1;
        no_ack = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (i_ack || d_ack) no_ack++;
        end
        chk("t6_no_ack_after", no_ack, 0);
        // Request presented across release is sampled at the first edge
        @(posedge clk); #3 reset_n = 0;
        #10 reset_n = 1;
        do_txn(0, 0, 64'h10, 32'h0);
        chk("t6_new_ack_cycle", r_ack_k, 4);
        chk("t6_new_rdata", r_rd, 32'h1234_5678);

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            if (i_req && i_ack) begin
                if ($urandom_range(0, 7) != 0) i_req = 0;
                else i_addr = rand_i_addr();
            end else if (!i_req) begin
                if ($urandom_range(0, 2) == 0) begin i_req = 1; i_addr = rand_i_addr(); end
            end else if ($urandom_range(0, 3) == 0) begin
                i_addr = rand_i_addr();
            end
            if (d_req && d_ack) begin
                if ($urandom_range(0, 7) != 0) d_req = 0;
                else begin d_addr = rand_d_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom(); end
            end else if (!d_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_req = 1; d_addr = rand_d_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom();
                end
            end else if ($urandom_range(0, 3) == 0) begin
                d_addr = rand_d_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom();
            end
            @(posedge clk); #1;
        end
        i_req = 0; d_req = 0;
        repeat (10) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
